// File: rtl/seq_sm_divide.sv
// seq_sm_divide: iterative sign-magnitude restoring divider, one quotient bit per clock.
// Operands and results are N+1 bits: sign in bit N, unsigned magnitude below it.
module seq_sm_divide #(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [N:0] x,
    input  logic [N:0] y,
    output logic       busy,
    output logic       done,
    output logic [N:0] res,
    output logic [N:0] rem,
    output logic       dbz
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic {IDLE, CALC} state_t;
    state_t state, state_n;
    logic [N-1:0] q, d, p, q_n, p_n;
    logic [N:0] sh_p, diff;
    logic [CW-1:0] cnt;
    logic xs, ys, dz, acc;
    always_comb begin
        acc = start && !busy;
        sh_p = {p, q[N-1]};
        diff = sh_p - {1'b0, d};
        p_n = diff[N] ? sh_p[N-1:0] : diff[N-1:0];
        q_n = {q[N-2:0], ~diff[N]};
        state_n = (state == IDLE) ? ((acc && |y[N-1:0]) ? CALC : IDLE)
                                  : ((cnt == CW'(1)) ? IDLE : CALC);
    end
    // dz marks a zero-divisor request: it completes one edge after acceptance without CALC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q <= '0;
            d <= '0;
            p <= '0;
            cnt <= '0;
            xs <= 1'b0;
            ys <= 1'b0;
            dz <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            res <= '0;
            rem <= '0;
            dbz <= 1'b0;
        end else begin
            state <= state_n;
            done <= 1'b0;
            if (acc) begin
                q <= x[N-1:0];
                d <= y[N-1:0];
                xs <= x[N];
                ys <= y[N];
                p <= '0;
                cnt <= CW'(N);
                busy <= 1'b1;
                dz <= ~|y[N-1:0];
            end else if (dz) begin
                dz <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
                dbz <= 1'b1;
                res <= {1'b0, {N{1'b1}}};
                rem <= {xs & |q, q};
            end else if (state == CALC) begin
                p <= p_n;
                q <= q_n;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    dbz <= 1'b0;
                    res <= {(xs ^ ys) & |q_n, q_n};
                    rem <= {xs & |p_n, p_n};
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_sm_divide.sv
// tb_seq_sm_divide: scoreboard bench for seq_sm_divide at N=4, 8 and 16.
module tb_seq_sm_divide;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic st4 = 1'b0, st8 = 1'b0, st16 = 1'b0;
    logic [4:0] x4 = '0, y4 = '0, res4, rem4;
    logic [8:0] x8 = '0, y8 = '0, res8, rem8;
    logic [16:0] x16 = '0, y16 = '0, res16, rem16;
    logic busy4, done4, dbz4, busy8, done8, dbz8, busy16, done16, dbz16;
    int vectors = 0, miscompares = 0;
    logic [34:0] sb[$];

    seq_sm_divide #(.N(4)) u4 (.clk(clk), .rst(rst), .start(st4), .x(x4), .y(y4),
        .busy(busy4), .done(done4), .res(res4), .rem(rem4), .dbz(dbz4));
    seq_sm_divide #(.N(8)) u8 (.clk(clk), .rst(rst), .start(st8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .res(res8), .rem(rem8), .dbz(dbz8));
    seq_sm_divide #(.N(16)) u16 (.clk(clk), .rst(rst), .start(st16), .x(x16), .y(y16),
        .busy(busy16), .done(done16), .res(res16), .rem(rem16), .dbz(dbz16));

    // reference: {dbz, res, rem}, each result zero-extended to 17 bits
    function automatic logic [34:0] model(int n, logic [16:0] a, logic [16:0] b);
        logic [16:0] m, am, bm, qm, rm, sgn;
        m = (17'd1 << n) - 17'd1;
        sgn = 17'd1 << n;
        am = a & m;
        bm = b & m;
        if (bm == 0)
            return {1'b1, m, (a[n] && am != 0) ? (am | sgn) : am};
        qm = am / bm;
        rm = am % bm;
        return {1'b0, ((a[n] ^ b[n]) && qm != 0) ? (qm | sgn) : qm,
                (a[n] && rm != 0) ? (rm | sgn) : rm};
    endfunction

    function automatic logic dn(int n);
        return n == 4 ? done4 : n == 8 ? done8 : done16;
    endfunction

    function automatic logic bs(int n);
        return n == 4 ? busy4 : n == 8 ? busy8 : busy16;
    endfunction

    task automatic go(input int n, input logic [16:0] a, input logic [16:0] b);
        @(negedge clk);
        if (n == 4) begin x4 = a[4:0]; y4 = b[4:0]; st4 = 1'b1; end
        else if (n == 8) begin x8 = a[8:0]; y8 = b[8:0]; st8 = 1'b1; end
        else begin x16 = a; y16 = b; st16 = 1'b1; end
        sb.push_back(model(n, a, b));
        @(negedge clk);
        st4 = 1'b0; st8 = 1'b0; st16 = 1'b0;
        x4 = 5'($urandom); y4 = 5'($urandom);
        x8 = 9'($urandom); y8 = 9'($urandom);
        x16 = 17'($urandom); y16 = 17'($urandom);
    endtask

    task automatic collect(input int n, output int cyc, output int bc, output logic [34:0] obs,
                           output logic bz);
        cyc = 0;
        bc = 0;
        while (!dn(n) && cyc < 200) begin
            if (bs(n)) bc++;
            @(negedge clk);
            cyc++;
        end
        obs = n == 4 ? {dbz4, 17'(res4), 17'(rem4)} : n == 8 ? {dbz8, 17'(res8), 17'(rem8)}
                                                           : {dbz16, 17'(res16), 17'(rem16)};
        bz = bs(n);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy4, done4, dbz4, res4, rem4, busy8, done8, dbz8, res8, rem8,
             busy16, done16, dbz16, res16, rem16} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got r8=%h m8=%h b8=%b d8=%b z8=%b want all 0",
                     res8, rem8, busy8, done8, dbz8);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [8:0] xs[6] = '{9'h064, 9'h164, 9'h164, 9'h105, 9'h0FF, 9'h0C8};
        logic [8:0] ys[6] = '{9'h007, 9'h007, 9'h107, 9'h009, 9'h001, 9'h00A};
        int cyc, bc;
        logic [34:0] obs, exp;
        logic bz;
        for (int i = 0; i < 6; i++) begin
            go(8, 17'(xs[i]), 17'(ys[i]));
            collect(8, cyc, bc, obs, bz);
            exp = sb.pop_front();
            vectors++;
            if (obs !== exp) begin miscompares++; $display("FAIL basic_%0d: got %h want %h", i, obs, exp); end
            vectors++;
            if (cyc !== 8 || bc !== 8 || bz !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_lat_%0d: got lat=%0d busy=%0d bz=%b want 8/8/0", i, cyc, bc, bz);
            end
        end
    endtask

    task automatic test_dbz();
        int cyc, bc;
        logic [34:0] obs, exp;
        logic bz;
        go(8, 17'h02A, 17'h100);
        collect(8, cyc, bc, obs, bz);
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp || obs !== {1'b1, 17'h0FF, 17'h02A}) begin
            miscompares++; $display("FAIL dbz: got %h want %h", obs, exp);
        end
        vectors++;
        if (cyc !== 1 || bz !== 1'b0) begin miscompares++; $display("FAIL dbz_lat: got %0d want 1", cyc); end
        go(8, 17'h064, 17'h007);
        collect(8, cyc, bc, obs, bz);
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL dbz_clear: got %h want %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        logic [34:0] obs, exp;
        logic bz;
        go(8, 17'h064, 17'h007);
        repeat (3) @(negedge clk);
        x8 = 9'h050; y8 = 9'h004; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        collect(8, cyc, bc, obs, bz);
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp || cyc !== 4) begin
            miscompares++; $display("FAIL ignored_start: got %h lat=%0d want %h lat=4", obs, cyc, exp);
        end
        x8 = 9'h050; y8 = 9'h004; st8 = 1'b1;
        sb.push_back(model(8, 17'h050, 17'h004));
        @(negedge clk);
        st8 = 1'b0;
        collect(8, cyc, bc, obs, bz);
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp || cyc !== 8) begin
            miscompares++; $display("FAIL back_to_back: got %h lat=%0d want %h lat=8", obs, cyc, exp);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, bc, seen;
        logic [34:0] obs, exp;
        logic bz;
        go(8, 17'h064, 17'h007);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy8, done8, dbz8, res8, rem8} !== '0) begin
            miscompares++; $display("FAIL abort_clear: got r=%h m=%h b=%b want 0", res8, rem8, busy8);
        end
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (done8) seen++; end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("FAIL abort_done: got %0d pulses want 0", seen); end
        go(8, 17'h0C8, 17'h00A);
        collect(8, cyc, bc, obs, bz);
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp || cyc !== 8) begin
            miscompares++; $display("FAIL abort_restart: got %h lat=%0d want %h", obs, cyc, exp);
        end
    endtask

    task automatic test_sweep(input int n);
        int cyc, bc;
        logic [34:0] obs, exp;
        logic [16:0] a, b, m;
        logic bz;
        m = (17'd1 << (n + 1)) - 17'd1;
        for (int i = 0; i < 40; i++) begin
            a = 17'($urandom) & m;
            b = 17'($urandom) & m;
            if ($urandom_range(0, 7) == 0) b = b & (17'd1 << n);
            go(n, a, b);
            collect(n, cyc, bc, obs, bz);
            exp = sb.pop_front();
            vectors++;
            if (obs !== exp || cyc !== (exp[34] ? 1 : n) || bz !== 1'b0) begin
                miscompares++;
                $display("FAIL sweep%0d_%0d: x=%h y=%h got %h lat=%0d want %h", n, i, a, b, obs, cyc, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dbz();
        test_back_to_back();
        test_reset_abort();
        test_sweep(4);
        test_sweep(16);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_sm_divide.md
Name: seq_sm_divide

Overview:
- Iterative sign-magnitude divider for the ALU datapath; generalises the existing combinational 8-bit divider to N magnitude bits.
- Computes one quotient bit per clock (restoring division) with a start/done handshake.
- Adds divide-by-zero detection and suppression of negative zero.
- Operand format: bit N = sign (1 = negative), bits N-1:0 = unsigned magnitude.

Parameters:
- N, 8, magnitude width in bits; operands and results are N+1 bits wide. Legal range is N ≥ 2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division; accepted only when busy=0
- x  input  N+1  dividend, sign-magnitude, sampled on the accepting edge
- y  input  N+1  divisor, sign-magnitude, sampled on the accepting edge
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when res/rem/dbz are updated
- res  output  N+1  quotient, sign-magnitude
- rem  output  N+1  remainder, sign-magnitude
- dbz  output  1  divide-by-zero flag for the last completed operation

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, dbz = 0; res, rem = 0; all internal registers = 0.
- A reset asserted mid-operation aborts the division. No done pulse is produced.
- States: IDLE, CALC.
- IDLE, start=1 on edge k:
  - Latch x magnitude into the quotient shift register, |y| into the divisor register, and both signs.
  - Clear the partial remainder (N+1 bits, to absorb the trial subtract).
  - Load count=N; set busy=1; go to CALC.
- Zero divisor: if |y|=0 on the accepting edge k, skip CALC and stay in IDLE. On edge k+1:
  - done=1, dbz=1, busy=0.
  - res = {1'b0, all ones}; rem = x as captured.
- CALC, each edge:
  - Shift {partial remainder, quotient} left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set quotient LSB=1; otherwise restore and set LSB=0.
  - Decrement count.
- The iteration with count=1 is the last one; it occurs on edge k+N. On that edge:
  - res and rem are written.
  - done=1 for exactly one cycle; busy=0; dbz=0; state returns to IDLE.
- Latency: N cycles from the accepting edge to done (8 for the default). Throughput: a new start is accepted on the cycle done is high, i.e. back-to-back operation is allowed.
- Sign rules:
  - res sign = x sign XOR y sign, forced to 0 when the quotient magnitude is 0.
  - rem sign = x sign (truncating division), forced to 0 when the remainder magnitude is 0.
  - Never output negative zero.
- Input -0 (sign=1, magnitude=0) is treated as 0.
- start while busy=1 is ignored: no queueing, no error, and the current operation is unaffected.
- Changes on x and y after the accepting edge have no effect.
- res, rem and dbz hold their values until the next completion or reset.
- done is never high in the same cycle as busy=1.

Test Plan:
- N=8; start with x=9'h064 (100), y=9'h007 (7) → after 8 cycles done=1, res=9'h00E, rem=9'h002, dbz=0; busy high for exactly 8 cycles.
- x=9'h164 (-100), y=9'h007 → res=9'h10E (-14), rem=9'h102 (-2). Then x=9'h164, y=9'h107 → res=9'h00E, rem=9'h102.
- x=9'h105 (-5), y=9'h009 → res=9'h000 (no negative zero), rem=9'h105. Also x=9'h0FF, y=9'h001 → res=9'h0FF, rem=9'h000.
- y=9'h100 (-0), x=9'h02A → done one cycle after start, dbz=1, res=9'h0FF, rem=9'h02A. The next valid division clears dbz.
- Pulse start with x=9'h050, y=9'h004 during the 4th busy cycle of a running 100/7 operation → ignored; result is 14 r 2. Then start on the done cycle → accepted, giving res=9'h014 after 8 more cycles.
- Assert rst at busy cycle 3 → busy, done, res, rem, dbz = 0 immediately; no done pulse; a fresh start afterwards completes correctly.
- Sweep N=4 and N=16 with random operands against a reference model → every result matches, latency equals N.
